// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment font, off pattern and output polarity helper.
package seg7_pkg;

    // {g,f,e,d,c,b,a}, active high, entry n is hex digit n
    localparam logic [15:0][6:0] SEG7_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [7:0] pol(input logic [7:0] x, input logic active_low);
        return active_low ? ~x : x;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-high a..g segments.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG7_FONT[hex];

endmodule

// File: rtl/seven_seg_scan_n.sv
// seven_seg_scan_n: multiplexed seven-segment scanner with PWM dimming, guard time,
// leading-zero suppression and frame-aligned double-buffered digit updates.
module seven_seg_scan_n
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int TICKS_DIGIT = 50000,
    parameter int BRIGHT_BITS = 3,
    parameter int GUARD       = 16,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digit_vals,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      lz_suppress,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    input  logic                      load,
    output logic                      busy,
    output logic                      frame_start,
    output logic [7:0]                SMG_Data,
    output logic [NUM_DIGITS-1:0]     Scan_Sig
);

    localparam int CW = $clog2(TICKS_DIGIT);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int STEP = TICKS_DIGIT >> BRIGHT_BITS;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TICKS_DIGIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic POL_LOW = ACTIVE_LOW != 0;

    logic [CW-1:0]           count;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] act_vals, sh_vals;
    logic [NUM_DIGITS-1:0]   act_dp, sh_dp, act_blank, sh_blank, lz_mask, sel;
    logic                    act_lz, sh_lz;
    logic                    zero_above, last, swap, in_win, suppressed, cur_dp, lit;
    logic [31:0]             on_limit;
    logic [3:0]              cur;
    logic [6:0]              font_seg;
    logic [7:0]              seg_hi;

    seg7_hex_decode u_dec (
        .hex(cur),
        .seg(font_seg)
    );

    // A digit is suppressed when it and every digit above it are zero; digit 0 never is
    always_comb begin
        lz_mask = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (act_vals[4*i +: 4] == 4'd0);
            lz_mask[i] = act_lz && zero_above;
        end
    end

    always_comb begin
        last       = count == LAST_COUNT && idx == LAST_IDX;
        swap       = busy && (!en || last);
        cur        = act_vals[{idx, 2'b00} +: 4];
        cur_dp     = act_dp[idx];
        suppressed = lz_mask[idx];
        on_limit   = 32'(GUARD) + (32'(brightness) + 32'd1) * 32'(STEP);
        in_win     = 32'(count) >= 32'(GUARD) && 32'(count) < on_limit;
        // A suppressed digit stays selected only to show its decimal point
        lit        = en && in_win && !act_blank[idx] && (!suppressed || cur_dp);
        seg_hi     = lit ? {cur_dp, suppressed ? 7'd0 : font_seg} : SEG_OFF;
        sel        = lit ? (NUM_DIGITS'(1) << idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            idx   <= '0;
        end else if (!en) begin
            count <= '0;
            idx   <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
            idx   <= idx == LAST_IDX ? '0 : idx + IW'(1);
        end else begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            act_vals  <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            act_lz    <= 1'b0;
            sh_vals   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_lz     <= 1'b0;
        end else begin
            if (swap) begin
                act_vals  <= sh_vals;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                act_lz    <= sh_lz;
            end
            if (load) begin
                sh_vals  <= digit_vals;
                sh_dp    <= dp_mask;
                sh_blank <= blank_mask;
                sh_lz    <= lz_suppress;
            end
            busy <= load || (busy && !swap);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            SMG_Data    <= pol(SEG_OFF, POL_LOW);
            Scan_Sig    <= NUM_DIGITS'(pol(8'h00, POL_LOW));
            frame_start <= 1'b0;
        end else begin
            SMG_Data    <= pol(seg_hi, POL_LOW);
            Scan_Sig    <= NUM_DIGITS'(pol(8'(sel), POL_LOW));
            frame_start <= en && count == '0 && idx == '0;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// tb_seven_seg_scan_n: directed stimulus against a position-based reference model,
// compared every cycle, plus hand-computed segment/scan/timing expectations.
module tb_seven_seg_scan_n;

    localparam int N = 4;
    localparam int T = 16;
    localparam int BB = 2;
    localparam int G = 2;
    localparam int STEP = T >> BB;
    localparam int FRAME = T * N;

    logic clk = 1'b0;
    logic reset_n, en, lz_suppress, load;
    logic [4*N-1:0] digit_vals;
    logic [N-1:0] dp_mask, blank_mask;
    logic [BB-1:0] brightness;
    logic busy, frame_start;
    logic [7:0] SMG_Data;
    logic [N-1:0] Scan_Sig;

    int checks = 0;
    int failures = 0;
    logic chk_on = 1'b0;
    int lows [N];
    int n;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seven_seg_scan_n #(
        .NUM_DIGITS(N), .TICKS_DIGIT(T), .BRIGHT_BITS(BB), .GUARD(G), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .digit_vals(digit_vals),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_suppress(lz_suppress),
        .brightness(brightness), .load(load), .busy(busy), .frame_start(frame_start),
        .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig)
    );

    always #5 clk = ~clk;

    // Model: frame position since enable, plus active/shadow copies of the display data
    int m_pos;
    logic [4*N-1:0] m_vals, s_vals;
    logic [N-1:0] m_dp, s_dp, m_blank, s_blank;
    logic m_lz, s_lz, m_busy;
    logic [7:0] exp_smg;
    logic [N-1:0] exp_scan;
    logic exp_busy, exp_fs;

    function automatic int top_digit();
        int top = 0;
        for (int j = 0; j < N; j++) if (m_vals[4*j +: 4] != 4'd0) top = j;
        return top;
    endfunction

    function automatic logic model_lit();
        int c = m_pos % T;
        int d = m_pos / T;
        logic sup = m_lz && d > top_digit();
        return en && c >= G && c < G + (int'(brightness) + 1) * STEP && !m_blank[d] && !(sup && !m_dp[d]);
    endfunction

    function automatic logic [7:0] model_smg();
        int d = m_pos / T;
        logic sup = m_lz && d > top_digit();
        return model_lit() ? ~{m_dp[d], sup ? 7'h00 : font[m_vals[4*d +: 4]]} : 8'hFF;
    endfunction

    function automatic logic [N-1:0] model_scan();
        return model_lit() ? ~(N'(1) << (m_pos / T)) : '1;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_pos <= 0;
            m_vals <= '0; m_dp <= '0; m_blank <= '1; m_lz <= 1'b0; m_busy <= 1'b0;
            exp_smg <= 8'hFF; exp_scan <= '1; exp_busy <= 1'b0; exp_fs <= 1'b0;
        end else begin
            exp_smg <= model_smg();
            exp_scan <= model_scan();
            exp_fs <= en && m_pos == 0;
            if (m_busy && (!en || m_pos == FRAME - 1)) begin
                m_vals <= s_vals; m_dp <= s_dp; m_blank <= s_blank; m_lz <= s_lz;
            end
            if (load) begin
                s_vals <= digit_vals; s_dp <= dp_mask; s_blank <= blank_mask; s_lz <= lz_suppress;
            end
            m_busy <= load || (m_busy && !(!en || m_pos == FRAME - 1));
            exp_busy <= load || (m_busy && !(!en || m_pos == FRAME - 1));
            m_pos <= en ? (m_pos + 1) % FRAME : 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_smg", 32'(SMG_Data), 32'(exp_smg));
            check("cmp_scan", 32'(Scan_Sig), 32'(exp_scan));
            check("cmp_busy", 32'(busy), 32'(exp_busy));
            check("cmp_fs", 32'(frame_start), 32'(exp_fs));
        end
    end

    task automatic at(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Advance to the next frame_start; cyc returns the number of cycles taken
    task automatic wait_fs(output int cyc);
        logic got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            cyc++;
            got = frame_start;
        end
        check("fs_timeout", 32'(got), 32'd1);
    endtask

    task automatic count_frame();
        for (int b = 0; b < N; b++) lows[b] = 0;
        for (int i = 0; i < FRAME; i++) begin
            for (int b = 0; b < N; b++) if (!Scan_Sig[b]) lows[b]++;
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [N-1:0] dp, input logic [N-1:0] bl, input logic lz);
        digit_vals = v; dp_mask = dp; blank_mask = bl; lz_suppress = lz; load = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; load = 1'b0; digit_vals = '0;
        dp_mask = '0; blank_mask = '0; lz_suppress = 1'b0; brightness = 2'd3;
        at(1);
        chk_on = 1'b1;
        at(2);
        check("rst_smg", 32'(SMG_Data), 32'hFF);
        check("rst_scan", 32'(Scan_Sig), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        reset_n = 1'b1; en = 1'b1;
        at(1);
        do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        at(1);
        load = 1'b0;
        check("t1_busy_set", 32'(busy), 32'd1);
        wait_fs(n);
        check("t1_busy_clr", 32'(busy), 32'd0);
        at(1);
        check("t1_guard", 32'(Scan_Sig), 32'hF);
        at(1);
        check("t1_d0_smg", 32'(SMG_Data), 32'h99);
        check("t1_d0_scan", 32'(Scan_Sig), 32'hE);
        at(16);
        check("t1_d1_smg", 32'(SMG_Data), 32'hB0);
        check("t1_d1_scan", 32'(Scan_Sig), 32'hD);
        wait_fs(n);
        check("t1_fs_rest", 32'(n), 32'd46);
        wait_fs(n);
        check("t1_fs_period", 32'(n), 32'd64);
        brightness = 2'd0;
        wait_fs(n);
        count_frame();
        check("t2_low0", 32'(lows[0]), 32'd4);
        check("t2_low3", 32'(lows[3]), 32'd4);
        brightness = 2'd3;
        do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
        at(1);
        load = 1'b0;
        wait_fs(n);
        count_frame();
        check("t3_low3", 32'(lows[3]), 32'd0);
        check("t3_low2", 32'(lows[2]), 32'd0);
        check("t3_low1", 32'(lows[1]), 32'd14);
        check("t3_low0", 32'(lows[0]), 32'd14);
        at(2);
        check("t3_d0_smg", 32'(SMG_Data), 32'hC0);
        at(16);
        check("t3_d1_smg", 32'(SMG_Data), 32'h92);
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        at(1);
        load = 1'b0;
        wait_fs(n);
        count_frame();
        check("t3z_low0", 32'(lows[0]), 32'd14);
        check("t3z_low1", 32'(lows[1]), 32'd0);
        check("t3z_low3", 32'(lows[3]), 32'd0);
        at(2);
        check("t3z_d0_smg", 32'(SMG_Data), 32'hC0);
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        at(1);
        digit_vals = 16'h2222;
        at(1);
        load = 1'b0;
        check("t4_busy", 32'(busy), 32'd1);
        wait_fs(n);
        check("t4_busy_clr", 32'(busy), 32'd0);
        at(2);
        check("t4_d0_smg", 32'(SMG_Data), 32'hA4);
        at(16);
        check("t4_d1_smg", 32'(SMG_Data), 32'hA4);
        do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
        at(1);
        load = 1'b0;
        at(44);
        do_load(16'h4444, 4'b0000, 4'b0000, 1'b0);
        at(1);
        load = 1'b0;
        check("t4_swap_fs", 32'(frame_start), 32'd1);
        check("t4_swap_busy", 32'(busy), 32'd1);
        at(2);
        check("t4_old_smg", 32'(SMG_Data), 32'hB0);
        wait_fs(n);
        check("t4_new_period", 32'(n), 32'd62);
        check("t4_new_busy", 32'(busy), 32'd0);
        at(2);
        check("t4_new_smg", 32'(SMG_Data), 32'h99);
        do_load(16'h1234, 4'b0100, 4'b0001, 1'b0);
        at(1);
        load = 1'b0;
        wait_fs(n);
        count_frame();
        check("t5_blank0", 32'(lows[0]), 32'd0);
        check("t5_low1", 32'(lows[1]), 32'd14);
        at(34);
        check("t5_dp_smg", 32'(SMG_Data), 32'h24);
        check("t5_dp_scan", 32'(Scan_Sig), 32'hB);
        do_load(16'h5678, 4'b0000, 4'b0000, 1'b0);
        at(1);
        load = 1'b0; en = 1'b0;
        check("t6_busy_pend", 32'(busy), 32'd1);
        at(1);
        check("t6_off_smg", 32'(SMG_Data), 32'hFF);
        check("t6_off_scan", 32'(Scan_Sig), 32'hF);
        check("t6_off_busy", 32'(busy), 32'd0);
        check("t6_off_fs", 32'(frame_start), 32'd0);
        at(3);
        en = 1'b1;
        at(1);
        check("t6_restart_fs", 32'(frame_start), 32'd1);
        at(2);
        check("t6_restart_smg", 32'(SMG_Data), 32'h80);
        check("t6_restart_scan", 32'(Scan_Sig), 32'hE);
        at(20);
        do_load(16'h9999, 4'b0000, 4'b0000, 1'b0);
        at(1);
        load = 1'b0; reset_n = 1'b0;
        at(1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_smg", 32'(SMG_Data), 32'hFF);
        check("t6_rst_scan", 32'(Scan_Sig), 32'hF);
        check("t6_rst_fs", 32'(frame_start), 32'd0);
        reset_n = 1'b1;
        wait_fs(n);
        count_frame();
        check("t6_dark0", 32'(lows[0]), 32'd0);
        check("t6_dark3", 32'(lows[3]), 32'd0);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
